// File: rtl/led_pattern_decoder_pkg.sv
// led_dec_pkg: shared mode, state and transition-class encodings for the LED pattern decoder
package led_dec_pkg;

  typedef enum logic [1:0] {
    MODE_NONE  = 2'd0,
    MODE_LEFT  = 2'd1,
    MODE_RIGHT = 2'd2,
    MODE_FILL  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CL_H = 3'd0,
    CL_L = 3'd1,
    CL_R = 3'd2,
    CL_F = 3'd3,
    CL_X = 3'd4
  } cls_t;

  // Hold and illegal transitions map to MODE_NONE so callers can treat that as "not a running step"
  function automatic mode_t cls_to_mode(input cls_t k);
    return (k == CL_L) ? MODE_LEFT : (k == CL_R) ? MODE_RIGHT : (k == CL_F) ? MODE_FILL : MODE_NONE;
  endfunction

endpackage

// File: rtl/led_step_classify.sv
// led_step_classify: classifies one LED step p->c and reports the position of the new sample
module led_step_classify
  import led_dec_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         p,
  input  logic [WIDTH-1:0]         c,
  output cls_t                     cls,
  output logic [$clog2(WIDTH)-1:0] pos
);

  localparam int PW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONES = '1;

  logic           p_onehot;
  logic           p_therm;
  logic           fill;
  logic [PW-1:0]  idx;
  logic [PW-1:0]  cnt;

  // Decide the class with H > L > R > F precedence; position is lit-bit index or popcount mod WIDTH
  always_comb begin
    p_onehot = (p != '0) && ((p & (p - WIDTH'(1))) == '0);
    p_therm  = ((p & (p + WIDTH'(1))) == '0) && (p != ONES);
    fill     = (p_therm && c == {p[WIDTH-2:0], 1'b1}) || (p == ONES && c == '0);
    cls      = (c == p) ? CL_H :
               (p_onehot && c == {p[WIDTH-2:0], p[WIDTH-1]}) ? CL_L :
               (p_onehot && c == {p[0], p[WIDTH-1:1]}) ? CL_R :
               fill ? CL_F : CL_X;
    idx = '0;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (c[i]) idx = PW'(i);
      cnt = cnt + PW'(c[i]);
    end
    pos = (cls == CL_F) ? cnt : idx;
  end

endmodule

// File: rtl/led_pattern_decoder.sv
// led_pattern_decoder: locks onto the LED shifter's running mode; LED_DEC_SYNC_EN adds input synchronisers and strobe edge detect
module led_pattern_decoder
  import led_dec_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         led_in,
  input  logic                     led_stb,
  output logic [1:0]               mode_det,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     locked,
  output logic                     err,
  output logic [ERR_W-1:0]         err_cnt
);

  localparam int PW = $clog2(WIDTH);
  localparam logic [3:0] RUN_LOCK = 4'(LOCK_CNT);

  logic [WIDTH-1:0] smp;
  logic             stb;

`ifdef LED_DEC_SYNC_EN
  logic [WIDTH-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [2:0]       stb_q, stb_d;

  // Two-flop synchronisers plus one extra strobe stage for rising-edge detection
  always_comb begin
    in1_d = led_in;
    in2_d = in1_q;
    stb_d = {stb_q[1:0], led_stb};
  end

  // Synchroniser registers
  always_ff @(posedge clk) begin
    if (reset) begin
      in1_q <= '0;
      in2_q <= '0;
      stb_q <= '0;
    end else begin
      in1_q <= in1_d;
      in2_q <= in2_d;
      stb_q <= stb_d;
    end
  end

  assign smp = in2_q;
  assign stb = stb_q[1] & ~stb_q[2];
`else
  assign smp = led_in;
  assign stb = led_stb;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [3:0]       run_q, run_d;
  mode_t            cand_q, cand_d;
  mode_t            mode_q, mode_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  cls_t             cls;
  logic [PW-1:0]    cpos;
  mode_t            cm;
  logic             valid;

  led_step_classify #(.WIDTH(WIDTH)) u_classify (
    .p   (prev_q),
    .c   (smp),
    .cls (cls),
    .pos (cpos)
  );

  // Acquisition/lock FSM; err is a one-cycle pulse, everything else holds between strobes
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    run_d     = run_q;
    cand_d    = cand_q;
    mode_d    = mode_q;
    pos_d     = pos_q;
    locked_d  = locked_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    cm        = cls_to_mode(cls);
    valid     = cm != MODE_NONE;
    if (stb) begin
      prev_d = smp;
      if (state_q != ST_IDLE && valid) pos_d = cpos;
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQ;
          run_d   = '0;
          cand_d  = MODE_NONE;
        end
        ST_ACQ: begin
          if (valid) begin
            run_d  = (cand_q == MODE_NONE || cand_q == cm) ? run_q + 4'd1 : 4'd1;
            cand_d = cm;
            if (run_d == RUN_LOCK) begin
              state_d  = ST_LOCK;
              locked_d = 1'b1;
              mode_d   = cm;
            end
          end else if (cls == CL_X) begin
            cand_d = MODE_NONE;
            run_d  = '0;
          end
        end
        ST_LOCK: begin
          if (cls != CL_H && cm != mode_q) begin
            err_d     = 1'b1;
            err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_W'(1);
            state_d   = ST_ACQ;
            locked_d  = 1'b0;
            mode_d    = MODE_NONE;
            cand_d    = cm;
            run_d     = valid ? 4'd1 : 4'd0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      prev_q    <= '0;
      run_q     <= '0;
      cand_q    <= MODE_NONE;
      mode_q    <= MODE_NONE;
      pos_q     <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      run_q     <= run_d;
      cand_q    <= cand_d;
      mode_q    <= mode_d;
      pos_q     <= pos_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign mode_det = mode_q;
  assign pos      = pos_q;
  assign locked   = locked_q;
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_led_pattern_decoder.sv
// tb_led_pattern_decoder: directed and randomized checks of led_pattern_decoder against a behavioural model
module tb_led_pattern_decoder;

  localparam int LOCK = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] led_in = '0;
  logic       led_stb = 1'b0;
  logic [1:0] mode_det;
  logic [2:0] pos;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;

  int n_tests = 0;
  int n_fail = 0;

  int m_seen, m_locked, m_mode, m_cand, m_run, m_pos, m_err, m_cnt, m_prev;

  led_pattern_decoder dut (
    .clk      (clk),
    .reset    (reset),
    .led_in   (led_in),
    .led_stb  (led_stb),
    .mode_det (mode_det),
    .pos      (pos),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  wire [14:0] dut_vec = {mode_det, pos, locked, err, err_cnt};

  function automatic logic [14:0] model_vec();
    logic [1:0] md;
    logic [2:0] ps;
    logic [7:0] ct;
    md = 2'(m_mode);
    ps = 3'(m_pos);
    ct = 8'(m_cnt);
    return {md, ps, m_locked != 0, m_err != 0, ct};
  endfunction

  function automatic int rl(input int x);
    return ((x << 1) | (x >> 7)) & 255;
  endfunction

  function automatic int rr(input int x);
    return ((x >> 1) | (x << 7)) & 255;
  endfunction

  // 0 hold, 1 left, 2 right, 3 fill, 4 illegal
  function automatic int classify(input int p, input int c);
    if (c == p) return 0;
    if ($countones(p) == 1 && c == rl(p)) return 1;
    if ($countones(p) == 1 && c == rr(p)) return 2;
    if ((p == (1 << $countones(p)) - 1 && p != 255 && c == 2 * p + 1) || (p == 255 && c == 0)) return 3;
    return 4;
  endfunction

  task automatic model_reset();
    m_seen = 0; m_locked = 0; m_mode = 0; m_cand = 0; m_run = 0;
    m_pos = 0; m_err = 0; m_cnt = 0; m_prev = 0;
  endtask

  task automatic model_step(input int c);
    int k;
    bit v;
    m_err = 0;
    if (m_seen == 0) begin
      m_seen = 1;
      m_run = 0;
      m_cand = 0;
    end else begin
      k = classify(m_prev, c);
      v = (k >= 1 && k <= 3);
      if (v) m_pos = (k == 3) ? ($countones(c) % 8) : $clog2(c);
      if (m_locked == 0) begin
        if (v) begin
          m_run = (m_cand == 0 || m_cand == k) ? m_run + 1 : 1;
          m_cand = k;
          if (m_run == LOCK) begin
            m_locked = 1;
            m_mode = k;
          end
        end else if (k == 4) begin
          m_cand = 0;
          m_run = 0;
        end
      end else if (k != 0 && k != m_mode) begin
        m_err = 1;
        if (m_cnt < 255) m_cnt++;
        m_locked = 0;
        m_mode = 0;
        m_cand = v ? k : 0;
        m_run = v ? 1 : 0;
      end
    end
    m_prev = c;
  endtask

  task automatic do_reset(input bit with_stb);
    reset = 1'b1;
    led_stb = with_stb;
    led_in = 8'h5A;
    @(posedge clk);
    #1;
    reset = 1'b0;
    led_stb = 1'b0;
    model_reset();
  endtask

  task automatic strobe(input int v);
    led_in = 8'(v);
    led_stb = 1'b1;
    @(posedge clk);
    #1;
    led_stb = 1'b0;
    model_step(v);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
    m_err = 0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    n_tests++;
    if (dut_vec !== 15'd0) begin
      n_fail++;
      $display("FAIL reset: got mode/pos/lk/err/cnt %h, required %h", dut_vec, 15'd0);
    end
  endtask

  task automatic test_lock_left();
    int seq[4] = '{8'h01, 8'h02, 8'h04, 8'h08};
    do_reset(1'b0);
    foreach (seq[i]) begin
      strobe(seq[i]);
      n_tests++;
      if (dut_vec !== model_vec() || locked !== 1'b0) begin
        n_fail++;
        $display("FAIL lock_left step %0d: got %h, required %h", i, dut_vec, model_vec());
      end
    end
    strobe(8'h10);
    n_tests++;
    if (dut_vec !== {2'd1, 3'd4, 1'b1, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL lock_left lock: got %h, required %h", dut_vec, {2'd1, 3'd4, 1'b1, 1'b0, 8'd0});
    end
  endtask

  task automatic test_wrap();
    strobe(8'h20);
    strobe(8'h40);
    strobe(8'h80);
    n_tests++;
    if (dut_vec !== {2'd1, 3'd7, 1'b1, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL wrap_0x80: got %h, required %h", dut_vec, {2'd1, 3'd7, 1'b1, 1'b0, 8'd0});
    end
    strobe(8'h01);
    n_tests++;
    if (dut_vec !== {2'd1, 3'd0, 1'b1, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL wrap_0x01: got %h, required %h", dut_vec, {2'd1, 3'd0, 1'b1, 1'b0, 8'd0});
    end
  endtask

  task automatic test_right_and_break();
    int seq[4] = '{8'h40, 8'h20, 8'h10, 8'h08};
    strobe(8'h80);
    n_tests++;
    if (dut_vec !== model_vec() || err !== 1'b1) begin
      n_fail++;
      $display("FAIL break_left: got %h, required %h", dut_vec, model_vec());
    end
    foreach (seq[i]) strobe(seq[i]);
    n_tests++;
    if ({mode_det, pos, locked} !== {2'd2, 3'd3, 1'b1} || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL lock_right: got %h, required %h", dut_vec, model_vec());
    end
    strobe(8'h10);
    n_tests++;
    if ({err, locked, mode_det} !== {1'b1, 1'b0, 2'd0} || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL break_right: got %h, required %h", dut_vec, model_vec());
    end
    idle(1);
    n_tests++;
    if (err !== 1'b0 || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL err_pulse_clear: got %h, required %h", dut_vec, model_vec());
    end
    strobe(8'h20);
    strobe(8'h40);
    strobe(8'h80);
    n_tests++;
    if ({mode_det, locked} !== {2'd1, 1'b1} || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL relock_left: got %h, required %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_fill();
    int seq[5] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F};
    int tail[5] = '{8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
    do_reset(1'b0);
    foreach (seq[i]) strobe(seq[i]);
    n_tests++;
    if (dut_vec !== {2'd3, 3'd4, 1'b1, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL fill_lock: got %h, required %h", dut_vec, {2'd3, 3'd4, 1'b1, 1'b0, 8'd0});
    end
    foreach (tail[i]) begin
      strobe(tail[i]);
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL fill_run step %0d: got %h, required %h", i, dut_vec, model_vec());
      end
    end
    n_tests++;
    if (dut_vec !== {2'd3, 3'd0, 1'b1, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL fill_wrap: got %h, required %h", dut_vec, {2'd3, 3'd0, 1'b1, 1'b0, 8'd0});
    end
    strobe(8'h00);
    n_tests++;
    if (dut_vec !== {2'd3, 3'd0, 1'b1, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL hold_zero: got %h, required %h", dut_vec, {2'd3, 3'd0, 1'b1, 1'b0, 8'd0});
    end
  endtask

  task automatic test_no_lock_and_reset_stb();
    int seq[2] = '{8'h01, 8'h02};
    do_reset(1'b0);
    repeat (6) strobe(8'h55);
    foreach (seq[i]) begin
      strobe(seq[i]);
      n_tests++;
      if (locked !== 1'b0 || err !== 1'b0 || dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL no_lock step %0d: got %h, required %h", i, dut_vec, model_vec());
      end
    end
    strobe(8'h04);
    strobe(8'h08);
    do_reset(1'b1);
    n_tests++;
    if (dut_vec !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_with_stb: got %h, required %h", dut_vec, 15'd0);
    end
    strobe(8'h01);
    n_tests++;
    if (dut_vec !== 15'd0) begin
      n_fail++;
      $display("FAIL idle_first_sample: got %h, required %h", dut_vec, 15'd0);
    end
    strobe(8'h02);
    strobe(8'h04);
    strobe(8'h08);
    strobe(8'h10);
    n_tests++;
    if (dut_vec !== {2'd1, 3'd4, 1'b1, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL lock_after_reset: got %h, required %h", dut_vec, {2'd1, 3'd4, 1'b1, 1'b0, 8'd0});
    end
  endtask

  task automatic test_saturation();
    int cur;
    bit left;
    do_reset(1'b0);
    cur = 8'h01;
    strobe(cur);
    repeat (LOCK) begin
      cur = rl(cur);
      strobe(cur);
    end
    left = 1'b1;
    for (int e = 1; e <= 300; e++) begin
      left = !left;
      repeat (LOCK) begin
        cur = left ? rl(cur) : rr(cur);
        strobe(cur);
      end
      if (e == 100) begin
        n_tests++;
        if (err_cnt !== 8'd100 || dut_vec !== model_vec()) begin
          n_fail++;
          $display("FAIL err_cnt_100: got %0d, required %0d", err_cnt, 100);
        end
      end
    end
    n_tests++;
    if (err_cnt !== 8'd255 || locked !== 1'b1 || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL err_cnt_saturate: got cnt %0d lk %b, required cnt 255 lk 1", err_cnt, locked);
    end
  endtask

  task automatic test_random();
    int cur, kind, nxt;
    do_reset(1'b0);
    cur = $urandom_range(0, 255);
    kind = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) kind = $urandom_range(1, 3);
      case ($urandom_range(0, 11))
        0: nxt = $urandom_range(0, 255);
        1: nxt = cur;
        default: begin
          if (kind == 3) nxt = (cur == 255) ? 0 : ((cur & (cur + 1)) == 0) ? 2 * cur + 1 : 0;
          else if ($countones(cur) != 1) nxt = 1 << $urandom_range(0, 7);
          else nxt = (kind == 1) ? rl(cur) : rr(cur);
        end
      endcase
      cur = nxt;
      strobe(cur);
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL random step %0d led %h: got %h, required %h", i, cur[7:0], dut_vec, model_vec());
      end
      if ($urandom_range(0, 7) == 0) begin
        idle($urandom_range(1, 3));
        n_tests++;
        if (dut_vec !== model_vec()) begin
          n_fail++;
          $display("FAIL random gap %0d: got %h, required %h", i, dut_vec, model_vec());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock_left();
    test_wrap();
    test_right_and_break();
    test_fill();
    test_no_lock_and_reset_stb();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
